mod_pwm_core: RTL and testbench

//   Fixed-period PWM generator: one output whose high time per period is set by a

---
 rtl/mod_pwm_pkg.sv | 12 +
 rtl/mod_pwm_tick.sv | 36 +++
 rtl/mod_pwm_core.sv | 61 ++++++
 tb/tb_mod_pwm_core.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mod_pwm_pkg.sv
// Shared defaults and helpers for the PWM core.
// The duty input is clamped to the period, so any request at or above 100% drives the output high.
package mod_pwm_pkg;

  localparam int unsigned PWM_PERIOD_DEF = 100;
  localparam int unsigned PWM_DUTY_W_DEF = 7;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/mod_pwm_tick.sv
// Prescaler: emits a one-cycle tick every PRESCALE clocks.
// When PRESCALE is 1 the tick is tied high.
module mod_pwm_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  if (PRESCALE <= 1) begin : g_no_div
    logic w_unused;
    assign w_unused = clock & reset;
    assign tick_o   = 1'b1;
  end else begin : g_div
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pcnt;
    logic          w_last;

    assign w_last = (r_pcnt == LAST);
    assign tick_o = w_last;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_pcnt <= '0;
      end else if (w_last) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_pwm_core.sv
// Fixed-period PWM generator.
// The duty value is latched only when the period wraps, so the width of a pulse never changes mid-period.
module mod_pwm_core
  import mod_pwm_pkg::*;
#(
  parameter int unsigned PERIOD   = PWM_PERIOD_DEF,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DUTY_W   = PWM_DUTY_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DUTY_W-1:0] io_dutyCycle,
  output logic              io_out
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Latched duty must be able to hold PERIOD itself (the 100% case).
  localparam int unsigned DQ_W  = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic             w_tick;
  logic             w_wrap;
  logic             w_cmp;
  logic [DQ_W-1:0]  w_duty_clamped;
  logic [CNT_W-1:0] r_cnt;
  logic [DQ_W-1:0]  r_duty;
  logic             r_out;

  mod_pwm_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick_o(w_tick)
  );

  assign w_wrap         = (r_cnt == CNT_LAST);
  assign w_duty_clamped = DQ_W'(clamp_duty(32'(io_dutyCycle), PERIOD));
  assign w_cmp          = (DQ_W'(r_cnt) < r_duty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_out  <= 1'b0;
    end else begin
      if (w_tick) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_duty <= w_duty_clamped;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      r_out <= w_cmp;
    end
  end

  assign io_out = r_out;

endmodule

// File: tb/tb_mod_pwm_core.sv
// Self-checking bench for mod_pwm_core at PERIOD=100, PRESCALE=1.
// A per-period duty history predicts io_out on every clock.
module tb_mod_pwm_core;

  localparam int unsigned PERIOD = 100;

  logic       clock;
  logic       reset;
  logic [6:0] io_dutyCycle;
  logic       io_out;

  int checks = 0;
  int fails  = 0;

  // Reference model state: edges since reset release, and the duty in force for each period.
  int k = 0;
  int pduty[$];

  mod_pwm_core #(
    .PERIOD  (PERIOD),
    .PRESCALE(1),
    .DUTY_W  (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_dutyCycle(io_dutyCycle),
    .io_out      (io_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int unsigned duty;
    int unsigned exp_high;
  } vec_t;

  vec_t vecs[8];

  function automatic int clampd(input int d);
    return (d > 100) ? 100 : d;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (io_out) hi++;
    end
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((k % 100) != 0 && n < 200);
    check("align", k % 100, 0);
  endtask

  task automatic model_reset();
    k = 0;
    pduty.delete();
    pduty.push_back(0);
  endtask

  // Per-edge monitor: output after edge k reflects phase (k-1)%100 of period (k-1)/100.
  initial begin
    int d;
    int phase;
    int exp;
    forever begin
      @(posedge clock);
      if (reset) begin
        k++;
        d = int'(io_dutyCycle);
        if ((k % 100) == 0) pduty.push_back(clampd(d));
        phase = (k - 1) % 100;
        exp = (phase < pduty[(k - 1) / 100]) ? 1 : 0;
        #1;
        check("out_cycle", int'(io_out), exp);
      end
    end
  end

  initial begin
    int hi;
    vecs[0] = '{duty: 0,   exp_high: 0};
    vecs[1] = '{duty: 10,  exp_high: 10};
    vecs[2] = '{duty: 20,  exp_high: 20};
    vecs[3] = '{duty: 50,  exp_high: 50};
    vecs[4] = '{duty: 99,  exp_high: 99};
    vecs[5] = '{duty: 100, exp_high: 100};
    vecs[6] = '{duty: 101, exp_high: 100};
    vecs[7] = '{duty: 127, exp_high: 100};

    // Reset and idle at 0% for three periods.
    reset = 1'b0;
    io_dutyCycle = 7'd0;
    model_reset();
    #20;
    check("reset_out", int'(io_out), 0);
    @(negedge clock);
    reset = 1'b1;
    count_high(300, hi);
    check("idle_zero_high", hi, 0);

    // Table: hold each duty a full period, then measure the period that uses it.
    for (int i = 0; i < 8; i++) begin
      wait_boundary();
      io_dutyCycle = 7'(vecs[i].duty);
      repeat (100) step();
      count_high(100, hi);
      check($sformatf("high_count_duty%0d", vecs[i].duty), hi, int'(vecs[i].exp_high));
    end

    // Mid-period change 30 -> 70 at cnt=40.
    wait_boundary();
    io_dutyCycle = 7'd30;
    repeat (100) step();
    count_high(40, hi);
    io_dutyCycle = 7'd70;
    begin
      int hi2;
      count_high(60, hi2);
      check("midchange_cur_period", hi + hi2, 30);
    end
    count_high(100, hi);
    check("midchange_next_period", hi, 70);

    // Async reset while the output is high.
    repeat (10) step();
    check("pre_reset_high", int'(io_out), 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_out", int'(io_out), 0);
    model_reset();
    #20;
    @(negedge clock);
    reset = 1'b1;
    count_high(100, hi);
    check("post_reset_low_period", hi, 0);
    count_high(100, hi);
    check("post_reset_duty70", hi, 70);

    // Random duties changed at random points; the monitor checks every cycle.
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(1, 150)) step();
      io_dutyCycle = 7'($urandom_range(0, 127));
    end
    wait_boundary();
    repeat (100) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
